ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath/control block.
- Owns the PC and computes next-PC from the datapath's nPC_sel and imm16.
- Fetches instruction words over a ready-handshaked instruction-memory port, then holds each word stable for the datapath until it is retired with advance.
- Replaces the fixed-latency fetch so the core runs against wait-stated memory.

Parameters:
RESET_PC, 32'h00400000, PC loaded on reset; bits [1:0] must be 00
WAIT_LIMIT, 16, maximum FETCH cycles without imem_ready before fetch error (1..65535)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
advance  input  1  datapath retires current instruction this cycle
nPC_sel  input  1  1 = take branch for the instruction being retired
imm16  input  16  branch offset (words, signed) of the instruction being retired
imem_ready  input  1  memory has valid imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
imem_req  output  1  fetch request, high throughout FETCH state
imem_addr  output  32  byte address of request, equals pc
inst  output  32  held instruction to the datapath
inst_valid  output  1  inst is valid and awaiting advance
pc  output  32  address of inst / current fetch
inst_count  output  32  number of retired instructions
fetch_err  output  1  sticky fetch timeout flag

Behaviour:
- Reset: single clock and synchronous active-high reset, as stated above.
  - Reset values: pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, inst_count=0, fetch_err=0, wait counter=0, state=IDLE.
  - Reset wins over every other event in the same cycle.
  - Reset mid-FETCH abandons the request; memory must tolerate a dropped request.
- States: IDLE, FETCH, HOLD, ERROR.
  - IDLE: imem_req=0; goes to FETCH unconditionally next cycle.
  - FETCH: imem_req=1, imem_addr=pc, both stable until imem_ready.
    - imem_ready=1 sampled at the edge: latch inst<=imem_rdata, clear wait counter, go to HOLD.
    - Otherwise increment wait counter. On the WAIT_LIMIT-th consecutive non-ready cycle go to ERROR, set fetch_err=1.
  - HOLD: inst_valid=1, imem_req=0, inst and pc stable.
    - advance=1: pc<=next_pc, inst_count<=inst_count+1, inst_valid<=0, go to FETCH.
    - advance=0: stay in HOLD, indefinitely.
  - ERROR: imem_req=0, inst_valid=0, fetch_err=1. Exits only by reset.
- advance is ignored outside HOLD; it must not alter pc, inst_count or state.
- nPC_sel and imm16 are sampled only on the HOLD-and-advance cycle.
- inst_valid is registered. It is 1 exactly when state=HOLD.
- next_pc:
  - nPC_sel=0: pc+4.
  - nPC_sel=1: pc+4+{{14{imm16[15]}},imm16,2'b00}.
  - 32-bit modulo arithmetic, wrap-around silent, no overflow flag.
  - pc[1:0] stays 00 by construction.
- Minimum latency: advance in cycle N, FETCH in N+1, imem_ready in N+1, inst_valid=1 in N+2. Throughput is one instruction per 2 cycles with zero-wait memory.
- Wait counter width: clog2(WAIT_LIMIT+1). It is cleared on entering FETCH.
- inst_count wraps from 0xFFFFFFFF to 0.
- imem_rdata is ignored whenever imem_ready=0 or state!=FETCH.

Test Plan:
1. Reset, RESET_PC=0x00400000, imem_ready tied 1 -> imem_req=0 during reset and the IDLE cycle. Then imem_req=1 with imem_addr=0x00400000. inst_valid=1 on the following cycle with inst=imem_rdata.
2. Sequential run: words 0x8C010000, 0x00221820, 0xAC030004, advance each HOLD with nPC_sel=0 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008. inst_count=3 after the third advance.
3. Branches:
   - At pc=0x00400008, nPC_sel=1, imm16=0x0003 -> next fetch 0x00400018.
   - At pc=0x00400018, nPC_sel=1, imm16=0xFFFF -> next fetch 0x00400018 (self-loop).
4. Wait states: imem_ready low 3 cycles then high -> imem_req high 4 consecutive cycles, imem_addr stable, inst_valid rises only after the ready edge. Holding advance=0 for 5 cycles keeps inst and pc constant.
5. Timeout: WAIT_LIMIT=8, imem_ready never asserted -> fetch_err=1 and imem_req=0 after the 8th FETCH cycle. State persists through advance pulses until reset, which clears fetch_err.
6. Boundaries:
   - Reset asserted in the 2nd wait cycle of FETCH -> pc=RESET_PC, state IDLE.
   - advance pulsed in FETCH -> no pc or count change.
   - pc=0xFFFFFFFC retired with nPC_sel=0 -> next fetch address 0x00000000.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory request/response bus for ifetch_unit
interface ifetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC owner and wait-state tolerant instruction fetch stage
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h00400000,
   parameter int          WAIT_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 advance,
   input  logic                 nPC_sel,
   input  logic [15:0]          imm16,
   ifetch_unit_if.master        imem,
   output logic [31:0]          inst,
   output logic                 inst_valid,
   output logic [31:0]          pc,
   output logic [31:0]          inst_count,
   output logic                 fetch_err
);

   localparam int WC = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [WC-1:0]   wait_cnt;
   logic            accept;
   logic            retire;
   logic            timeout;
   logic [31:0]     branch_off;
   logic [31:0]     next_pc;

   // Branch offset is in words; sign-extend then scale to bytes so pc[1:0] stays 00.
   assign branch_off = nPC_sel ? {{14{imm16[15]}}, imm16, 2'b00} : 32'd0;
   assign next_pc    = pc + 32'd4 + branch_off;

   assign imem.imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      retire        = 1'b0;
      timeout       = 1'b0;
      imem.imem_req = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            imem.imem_req = 1'b1;
            if (imem.imem_ready) begin
               accept    = 1'b1;
               state_nxt = HOLD;
            end else if (wait_cnt == WC'(WAIT_LIMIT - 1)) begin
               timeout   = 1'b1;
               state_nxt = ERROR;
            end
         end
         HOLD: begin
            if (advance) begin
               retire    = 1'b1;
               state_nxt = FETCH;
            end
         end
         ERROR: begin
            state_nxt = ERROR;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         inst       <= 32'd0;
         inst_valid <= 1'b0;
         inst_count <= 32'd0;
         fetch_err  <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         inst_valid <= (state_nxt == HOLD);
         if (accept) begin
            inst <= imem.imem_rdata;
         end
         // Counter restarts on every entry into FETCH and on each accepted word.
         if (accept || retire || state == IDLE) begin
            wait_cnt <= '0;
         end else if (state == FETCH) begin
            wait_cnt <= wait_cnt + WC'(1);
         end
         if (retire) begin
            pc         <= next_pc;
            inst_count <= inst_count + 32'd1;
         end
         if (timeout) begin
            fetch_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;
   logic        clk;
   logic        reset;
   logic        advance;
   logic        npc_sel;
   logic [15:0] imm16;

   logic [31:0] inst_a, pc_a, cnt_a;
   logic        valid_a, err_a;
   logic [31:0] inst_b, pc_b, cnt_b;
   logic        valid_b, err_b;

   int n_cmp;
   int n_bad;

   ifetch_unit_if bus_a ();
   ifetch_unit_if bus_b ();

   ifetch_unit #(.RESET_PC(32'h00400000), .WAIT_LIMIT(8)) dut_a (
      .clk(clk), .reset(reset), .advance(advance), .nPC_sel(npc_sel), .imm16(imm16),
      .imem(bus_a), .inst(inst_a), .inst_valid(valid_a), .pc(pc_a),
      .inst_count(cnt_a), .fetch_err(err_a)
   );

   ifetch_unit #(.RESET_PC(32'hFFFFFFFC), .WAIT_LIMIT(16)) dut_b (
      .clk(clk), .reset(reset), .advance(advance), .nPC_sel(npc_sel), .imm16(imm16),
      .imem(bus_b), .inst(inst_b), .inst_valid(valid_b), .pc(pc_b),
      .inst_count(cnt_b), .fetch_err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      advance = 1'b0;
      npc_sel = 1'b0;
      imm16 = 16'h0000;
      bus_a.imem_ready = 1'b1;
      bus_a.imem_rdata = 32'h8C010000;
      bus_b.imem_ready = 1'b1;
      bus_b.imem_rdata = 32'hDEADBEEF;

      step();
      step();
      check("rst_req", {31'd0, bus_a.imem_req}, 32'd0);
      check("rst_valid", {31'd0, valid_a}, 32'd0);
      check("rst_pc", pc_a, 32'h00400000);
      check("rst_inst", inst_a, 32'd0);
      check("rst_cnt", cnt_a, 32'd0);
      check("rst_err", {31'd0, err_a}, 32'd0);

      reset = 1'b0;
      step();
      check("f0_req", {31'd0, bus_a.imem_req}, 32'd1);
      check("f0_addr", bus_a.imem_addr, 32'h00400000);
      check("f0_valid", {31'd0, valid_a}, 32'd0);
      step();
      check("h0_valid", {31'd0, valid_a}, 32'd1);
      check("h0_inst", inst_a, 32'h8C010000);
      check("h0_req", {31'd0, bus_a.imem_req}, 32'd0);

      advance = 1'b1;
      step();
      advance = 1'b0;
      check("f1_addr", bus_a.imem_addr, 32'h00400004);
      check("f1_cnt", cnt_a, 32'd1);
      check("f1_valid", {31'd0, valid_a}, 32'd0);
      bus_a.imem_rdata = 32'h00221820;
      step();
      check("h1_inst", inst_a, 32'h00221820);
      advance = 1'b1;
      step();
      advance = 1'b0;
      check("f2_addr", bus_a.imem_addr, 32'h00400008);
      bus_a.imem_rdata = 32'hAC030004;
      step();
      check("h2_inst", inst_a, 32'hAC030004);

      advance = 1'b1;
      npc_sel = 1'b1;
      imm16 = 16'h0003;
      step();
      advance = 1'b0;
      npc_sel = 1'b0;
      imm16 = 16'h0000;
      check("br_fwd_addr", bus_a.imem_addr, 32'h00400018);
      check("br_cnt", cnt_a, 32'd3);
      bus_a.imem_rdata = 32'h1000FFFF;
      step();
      check("h3_inst", inst_a, 32'h1000FFFF);
      advance = 1'b1;
      npc_sel = 1'b1;
      imm16 = 16'hFFFF;
      step();
      advance = 1'b0;
      npc_sel = 1'b0;
      imm16 = 16'h0000;
      check("br_self_addr", bus_a.imem_addr, 32'h00400018);
      check("br_self_cnt", cnt_a, 32'd4);

      bus_a.imem_ready = 1'b0;
      bus_a.imem_rdata = 32'hBAD0BAD0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ws_req", {31'd0, bus_a.imem_req}, 32'd1);
         check("ws_addr", bus_a.imem_addr, 32'h00400018);
         check("ws_valid", {31'd0, valid_a}, 32'd0);
      end
      bus_a.imem_ready = 1'b1;
      bus_a.imem_rdata = 32'h12345678;
      step();
      check("ws_done_valid", {31'd0, valid_a}, 32'd1);
      check("ws_done_inst", inst_a, 32'h12345678);
      bus_a.imem_rdata = 32'h55555555;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_inst", inst_a, 32'h12345678);
         check("hold_pc", pc_a, 32'h00400018);
         check("hold_valid", {31'd0, valid_a}, 32'd1);
      end

      advance = 1'b1;
      step();
      check("f5_pc", pc_a, 32'h0040001C);
      check("f5_cnt", cnt_a, 32'd5);
      bus_a.imem_ready = 1'b0;
      step();
      advance = 1'b0;
      check("adv_fetch_pc", pc_a, 32'h0040001C);
      check("adv_fetch_cnt", cnt_a, 32'd5);
      check("adv_fetch_req", {31'd0, bus_a.imem_req}, 32'd1);

      reset = 1'b1;
      step();
      check("mid_rst_pc", pc_a, 32'h00400000);
      check("mid_rst_req", {31'd0, bus_a.imem_req}, 32'd0);
      check("mid_rst_cnt", cnt_a, 32'd0);
      reset = 1'b0;

      step();
      for (int i = 0; i < 7; i++) begin
         step();
         check("to_req", {31'd0, bus_a.imem_req}, 32'd1);
         check("to_err", {31'd0, err_a}, 32'd0);
      end
      step();
      check("to_err_set", {31'd0, err_a}, 32'd1);
      check("to_req_low", {31'd0, bus_a.imem_req}, 32'd0);
      bus_a.imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         advance = 1'b1;
         step();
         advance = 1'b0;
         step();
         check("err_sticky", {31'd0, err_a}, 32'd1);
         check("err_req", {31'd0, bus_a.imem_req}, 32'd0);
         check("err_valid", {31'd0, valid_a}, 32'd0);
         check("err_pc", pc_a, 32'h00400000);
         check("err_cnt", cnt_a, 32'd0);
      end
      reset = 1'b1;
      step();
      check("err_clear", {31'd0, err_a}, 32'd0);

      reset = 1'b0;
      step();
      step();
      check("wrap_valid", {31'd0, valid_b}, 32'd1);
      check("wrap_pc0", pc_b, 32'hFFFFFFFC);
      check("wrap_inst", inst_b, 32'hDEADBEEF);
      advance = 1'b1;
      step();
      advance = 1'b0;
      check("wrap_addr", bus_b.imem_addr, 32'h00000000);
      check("wrap_cnt", cnt_b, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
